// File: rtl/store_mem_unit_pkg.sv
// Shared MemCode definitions and byte-lane helpers for the MEM-stage load and store paths.
`default_nettype none

package store_mem_unit_pkg;

  typedef logic [3:0] mem_code_t;

  localparam mem_code_t MC_SW  = 4'b0000;
  localparam mem_code_t MC_SH  = 4'b0010;
  localparam mem_code_t MC_SB  = 4'b0011;
  localparam mem_code_t MC_LW  = 4'b1000;
  localparam mem_code_t MC_LH  = 4'b1010;
  localparam mem_code_t MC_LB  = 4'b1011;
  localparam mem_code_t MC_LHU = 4'b1110;
  localparam mem_code_t MC_LBU = 4'b1111;

  // Only the three store codes are legal on the store path.
  function automatic logic store_legal(input mem_code_t code, input logic [1:0] off);
    logic ok;
    case (code)
      MC_SW:   ok = (off == 2'b00);
      MC_SH:   ok = (off[0] == 1'b0);
      MC_SB:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for an access of the given width; shared with the load extractor.
  function automatic logic [3:0] lane_be(input mem_code_t code, input logic [1:0] off);
    logic [3:0] be;
    case (code)
      MC_SW, MC_LW:          be = 4'b1111;
      MC_SH, MC_LH, MC_LHU:  be = off[1] ? 4'b1100 : 4'b0011;
      MC_SB, MC_LB, MC_LBU:  be = 4'b0001 << off;
      default:               be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_code_t code, input logic [31:0] data);
    logic [31:0] wd;
    case (code)
      MC_SH:   wd = {2{data[15:0]}};
      MC_SB:   wd = {4{data[7:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_mem_unit_fifo.sv
// In-order store buffer: DEPTH x {word address, byte enables, write data} with per-entry valid bits.
`default_nettype none

module store_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 30
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [WORD_W-1:0]               push_word,
  input  logic [3:0]                      push_be,
  input  logic [31:0]                     push_data,
  input  logic                            pop,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                valid,
  output logic [DEPTH-1:0][WORD_W-1:0]    words,
  output logic [WORD_W-1:0]               head_word,
  output logic [3:0]                      head_be,
  output logic [31:0]                     head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [WORD_W-1:0] word_mem [DEPTH];
  logic [3:0]        be_mem   [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] push_mask;
  logic [DEPTH-1:0] pop_mask;

  assign do_push   = push && (count_q < CNT_W'(DEPTH));
  assign do_pop    = pop && (count_q != '0);
  assign push_mask = do_push ? (DEPTH'(1) << wr_ptr) : '0;
  assign pop_mask  = do_pop  ? (DEPTH'(1) << rd_ptr) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
      valid_q <= (valid_q & ~pop_mask) | push_mask;
    end
  end

  // Payload storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      word_mem[wr_ptr] <= push_word;
      be_mem[wr_ptr]   <= push_be;
      data_mem[wr_ptr] <= push_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_words
    assign words[g] = word_mem[g];
  end

  assign count     = count_q;
  assign valid     = valid_q;
  assign head_word = word_mem[rd_ptr];
  assign head_be   = be_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/store_mem_unit.sv
// MEM-stage store unit: legality check, lane alignment, AdES error capture, buffered drain and load hazard detect.
`default_nettype none

module store_mem_unit
  import store_mem_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_code,
  output logic              st_err,
  output logic [ADDR_W-1:0] st_err_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              drained
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]                count;
  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0][WORD_W-1:0]    words;
  logic [WORD_W-1:0]               head_word;
  logic                            accept;
  logic                            legal;
  logic                            push;
  logic                            pop;
  logic                            hit;
  logic                            err_q;
  logic [ADDR_W-1:0]               err_addr_q;
  logic                            unused_ld_off;

  assign st_ready = (count < CNT_W'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign legal    = store_legal(st_code, st_addr[1:0]);
  assign push     = accept && legal;
  assign mem_req  = (count != '0);
  assign pop      = mem_req && mem_ack;
  assign drained  = (count == '0);

  store_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (st_addr[ADDR_W-1:2]),
    .push_be   (lane_be(st_code, st_addr[1:0])),
    .push_data (lane_wdata(st_code, st_data)),
    .pop       (pop),
    .count     (count),
    .valid     (valid),
    .words     (words),
    .head_word (head_word),
    .head_be   (mem_be),
    .head_data (mem_wdata)
  );

  assign mem_addr = {head_word, 2'b00};

  // Error pulse covers only the cycle after an illegal accept; the address is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= accept && !legal;
      if (accept && !legal) err_addr_q <= st_addr;
    end
  end

  assign st_err      = err_q;
  assign st_err_addr = err_addr_q;

  // Word-granular compare; the entry being acked this cycle is still valid here.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (words[i] == ld_addr[ADDR_W-1:2])) hit = 1'b1;
    end
  end

  assign ld_hazard     = ld_valid && hit;
  assign unused_ld_off = ^ld_addr[1:0];

endmodule

`default_nettype wire
